// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, redirect flush, and dropping of stale responses.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets are word-aligned and flagged on misalign_err.
module instr_fetch #(
    parameter logic [31:0] INSTR_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        misalign_err
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] drop_addr;
    logic [XLEN-1:0] drop_addr_nxt;
    logic            if_valid_nxt;
    logic [XLEN-1:0] if_instr_nxt;
    logic [XLEN-1:0] if_pc_nxt;
    logic            misalign_nxt;
    logic [XLEN-1:0] redirect_tgt_c;
    logic            misalign_c;

    // Redirect target conditioning
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_c     = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt_c = {redirect_pc[XLEN-1:2], 2'b00};
`else
    assign misalign_c     = 1'b0;
    assign redirect_tgt_c = redirect_pc;
`endif

    // State and fetch-output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            drop_addr    <= '0;
            if_valid     <= 1'b0;
            if_instr     <= INSTR_NOP;
            if_pc        <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            drop_addr    <= drop_addr_nxt;
            if_valid     <= if_valid_nxt;
            if_instr     <= if_instr_nxt;
            if_pc        <= if_pc_nxt;
            misalign_err <= misalign_nxt;
        end
    end

    // Next-state, next-pc and memory request decode
    always_comb begin
        state_nxt     = state;
        drop_addr_nxt = drop_addr;
        if_valid_nxt  = if_valid;
        if_instr_nxt  = if_instr;
        if_pc_nxt     = if_pc;
        misalign_nxt  = misalign_c;
        imem_req      = 1'b0;
        imem_addr     = current_pc;
        next_pc       = current_pc;

        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    next_pc      = current_pc + INSTR_BYTES;
                    if_valid_nxt = 1'b1;
                    if_instr_nxt = imem_rdata;
                    if_pc_nxt    = current_pc;
                    state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (if_ready) begin
                    if_valid_nxt = 1'b0;
                    state_nxt    = REQ;
                end
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr;
                if (imem_ack) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Redirect overrides everything; an in-flight request without ack must be drained first
        if (redirect_valid) begin
            next_pc      = redirect_tgt_c;
            if_valid_nxt = 1'b0;
            if_instr_nxt = INSTR_NOP;
            if_pc_nxt    = if_pc;
            case (state)
                REQ: begin
                    if (imem_ack) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt     = DROP;
                        drop_addr_nxt = current_pc;
                    end
                end
                DROP:    state_nxt = imem_ack ? REQ : DROP;
                default: state_nxt = REQ;
            endcase
        end

        if (!reset) begin
            next_pc = current_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: pc-stage register model plus a scoreboard of accepted fetches.
module tb_instr_fetch;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] PC_RST = 32'h0100_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [31:0] MIS_TGT = 32'h0100_0004;
    localparam logic        MIS_ERR = 1'b1;
`else
    localparam logic [31:0] MIS_TGT = 32'h0100_0006;
    localparam logic        MIS_ERR = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk;
    logic        reset;
    logic [31:0] current_pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        misalign_err;

    fetch_t sb[$];
    int     checks = 0;
    int     errors = 0;

    instr_fetch #(.INSTR_NOP(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .current_pc     (current_pc),
        .next_pc        (next_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .misalign_err   (misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // pc stage: reloads next_pc every edge, resets to the boot address
    always @(posedge clk or negedge reset) begin
        if (!reset) current_pc <= PC_RST;
        else        current_pc <= next_pc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        fetch_t e;
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
    endtask

    task automatic consume(input string tag);
        fetch_t e;
        if_ready = 1'b1;
        #1;
        e.pc    = '1;
        e.instr = '1;
        if (sb.size() != 0) e = sb.pop_front();
        chk({tag, "_valid"}, 32'(if_valid), 32'd1);
        chk({tag, "_instr"}, if_instr, e.instr);
        chk({tag, "_pc"}, if_pc, e.pc);
    endtask

    initial begin
        reset          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        step();
        step();

        // reset values; redirect must not reach next_pc while in reset
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0200_0000;
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, NOP);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_next_pc", next_pc, PC_RST);
        redirect_valid = 1'b0;

        step();
        reset = 1'b1;
        #1;
        chk("idle_imem_req", 32'(imem_req), 32'd0);
        chk("idle_next_pc", next_pc, PC_RST);

        // first fetch, ack two cycles after request
        step();
        #1;
        chk("req0_imem_req", 32'(imem_req), 32'd1);
        chk("req0_addr", imem_addr, PC_RST);
        chk("req0_next_pc", next_pc, PC_RST);
        step();
        #1;
        chk("req0_wait_addr", imem_addr, PC_RST);
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_1111;
        push(PC_RST, 32'h1111_1111);
        #1;
        chk("ack0_next_pc", next_pc, PC_RST + 32'd4);
        chk("ack0_if_valid", 32'(if_valid), 32'd0);
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        #1;
        chk("hold_if_valid", 32'(if_valid), 32'd1);
        chk("hold_if_pc", if_pc, PC_RST);

        // decode stalls for five cycles
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_instr", if_instr, 32'h1111_1111);
            chk("stall_imem_req", 32'(imem_req), 32'd0);
            chk("stall_next_pc", next_pc, PC_RST + 32'd4);
            step();
            #1;
        end
        consume("fetch0");
        step();
        if_ready = 1'b0;
        #1;
        chk("req1_imem_req", 32'(imem_req), 32'd1);
        chk("req1_addr", imem_addr, PC_RST + 32'd4);

        // zero-latency ack
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_2222;
        push(PC_RST + 32'd4, 32'h2222_2222);
        #1;
        chk("ack1_next_pc", next_pc, PC_RST + 32'd8);
        step();
        imem_ack = 1'b0;
        #1;
        consume("fetch1");
        step();
        if_ready = 1'b0;
        #1;
        chk("req2_addr", imem_addr, PC_RST + 32'd8);

        // redirect while request outstanding, late ack dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0100;
        #1;
        chk("rdr_next_pc", next_pc, 32'h0100_0100);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("drop_imem_req", 32'(imem_req), 32'd1);
        chk("drop_addr1", imem_addr, PC_RST + 32'd8);
        chk("drop_next_pc", next_pc, 32'h0100_0100);
        chk("drop_if_valid", 32'(if_valid), 32'd0);
        chk("drop_if_instr", if_instr, NOP);
        step();
        #1;
        chk("drop_addr2", imem_addr, PC_RST + 32'd8);
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("drop_addr3", imem_addr, PC_RST + 32'd8);
        step();
        imem_ack = 1'b0;
        #1;
        chk("after_drop_if_valid", 32'(if_valid), 32'd0);
        chk("after_drop_imem_req", 32'(imem_req), 32'd1);
        chk("after_drop_addr", imem_addr, 32'h0100_0100);

        // redirect coincident with ack
        imem_ack       = 1'b1;
        imem_rdata     = 32'h3333_3333;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0040;
        #1;
        chk("rdr_ack_next_pc", next_pc, 32'h0100_0040);
        step();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rdr_ack_if_valid", 32'(if_valid), 32'd0);
        chk("rdr_ack_imem_req", 32'(imem_req), 32'd1);
        chk("rdr_ack_addr", imem_addr, 32'h0100_0040);
        step();
        #1;
        chk("rdr_ack_if_valid2", 32'(if_valid), 32'd0);

        // redirect with if_ready in HOLD, misaligned target
        imem_ack   = 1'b1;
        imem_rdata = 32'h4444_4444;
        step();
        imem_ack = 1'b0;
        #1;
        chk("hold2_if_valid", 32'(if_valid), 32'd1);
        chk("hold2_if_pc", if_pc, 32'h0100_0040);
        chk("hold2_if_instr", if_instr, 32'h4444_4444);
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0006;
        #1;
        chk("mis_next_pc", next_pc, MIS_TGT);
        step();
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("mis_if_valid", 32'(if_valid), 32'd0);
        chk("mis_if_instr", if_instr, NOP);
        chk("mis_err", 32'(misalign_err), 32'(MIS_ERR));
        chk("mis_imem_req", 32'(imem_req), 32'd1);
        chk("mis_addr", imem_addr, MIS_TGT);
        step();
        #1;
        chk("mis_err_pulse_end", 32'(misalign_err), 32'd0);

        // redirect into DROP, redirect again in DROP, then reset with a late ack
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0080;
        #1;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("drop2_addr", imem_addr, MIS_TGT);
        chk("drop2_next_pc", next_pc, 32'h0100_0080);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0090;
        #1;
        chk("drop2_rdr_next_pc", next_pc, 32'h0100_0090);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("drop2_stay_req", 32'(imem_req), 32'd1);
        chk("drop2_stay_addr", imem_addr, MIS_TGT);
        reset = 1'b0;
        #1;
        chk("midrst_imem_req", 32'(imem_req), 32'd0);
        chk("midrst_if_valid", 32'(if_valid), 32'd0);
        step();
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h5A5A_5A5A;
        #1;
        chk("late_ack_idle_req", 32'(imem_req), 32'd0);
        chk("late_ack_next_pc", next_pc, PC_RST);
        step();
        imem_ack = 1'b0;
        #1;
        chk("late_ack_if_valid", 32'(if_valid), 32'd0);
        chk("late_ack_imem_req", 32'(imem_req), 32'd1);
        chk("late_ack_addr", imem_addr, PC_RST);

        // normal fetch after reset recovery
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_5555;
        push(PC_RST, 32'h5555_5555);
        step();
        imem_ack = 1'b0;
        #1;
        consume("fetch_final");
        step();
        if_ready = 1'b0;
        #1;
        chk("final_addr", imem_addr, PC_RST + 32'd4);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
